// File: rtl/tri_bus_pkg.sv
// rtl/tri_bus_pkg.sv - shared types and constants for the tri-state bus arbiter
// Contents: FSM state enum, default driver count and hold limit, and the owner
// index width helper used to size owner/pointer signals.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    localparam int DEF_NUM_DRV  = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Width of a driver index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rtl/tri_bus_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports:
//   req_i   - request vector, one bit per driver
//   ptr_i   - index where the search starts (highest priority)
//   win_o   - index of the first requester at or after ptr_i, wrapping
//   found_o - high when any request bit is set
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int NUM_DRV = DEF_NUM_DRV
) (
    input  logic [NUM_DRV-1:0]               req_i,
    input  logic [idx_width(NUM_DRV)-1:0]    ptr_i,
    output logic [idx_width(NUM_DRV)-1:0]    win_o,
    output logic                             found_o
);

    localparam int IW = idx_width(NUM_DRV);

    always_comb begin
        int            pos;
        logic [IW-1:0] idx;
        found_o = 1'b0;
        win_o   = '0;
        pos     = 0;
        idx     = '0;
        for (int k = 0; k < NUM_DRV; k++) begin
            // ptr_i < NUM_DRV and k < NUM_DRV, so one subtract wraps it.
            pos = int'(ptr_i) + k;
            if (pos >= NUM_DRV) begin
                pos = pos - NUM_DRV;
            end
            idx = IW'(pos);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                win_o   = idx;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin owner of the active-low tri-state enables on one bus
// Optional feature macro: BUS_TURNAROUND_EN (inserts one all-high cycle between owners).
// Ports:
//   clk      - rising-edge clock
//   resetN   - synchronous active-low reset
//   req      - per-driver level request
//   enableN  - per-driver active-low enable, at most one bit low
//   owner    - current owner index, meaningful while bus_busy is high
//   bus_busy - high while any enable is low
//   preempt  - one-cycle pulse when an owner is released by the hold limit
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NUM_DRV  = DEF_NUM_DRV,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic [NUM_DRV-1:0]               req,
    output logic [NUM_DRV-1:0]               enableN,
    output logic [idx_width(NUM_DRV)-1:0]    owner,
    output logic                             bus_busy,
    output logic                             preempt
);

    localparam int             IW       = idx_width(NUM_DRV);
    localparam logic [7:0]     HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DRV - 1);

    state_e               state_q;
    logic [NUM_DRV-1:0]   enable_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        ptr_q;
    logic                 busy_q;
    logic                 preempt_q;
    logic [7:0]           hold_q;

    logic [IW-1:0]        ptr_rel;
    logic [IW-1:0]        pick_ptr;
    logic [IW-1:0]        win;
    logic                 found;
    logic [NUM_DRV-1:0]   own_mask;
    logic [NUM_DRV-1:0]   win_mask;
    logic                 own_drop;
    logic                 others;
    logic                 force_rel;

    always_comb begin
        ptr_rel   = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
        // While owning, search from the post-release pointer so a back-to-back
        // handover already ranks the outgoing owner last.
        pick_ptr  = (state_q == ST_OWN) ? ptr_rel : ptr_q;
        own_mask  = NUM_DRV'(1) << owner_q;
        win_mask  = NUM_DRV'(1) << win;
        own_drop  = ~|(req & own_mask);
        others    = |(req & ~own_mask);
        force_rel = ~own_drop & others & (hold_q >= HOLD_MAX);
    end

    rr_pick #(
        .NUM_DRV (NUM_DRV)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .win_o   (win),
        .found_o (found)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            enable_q  <= '1;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                ST_OWN: begin
                    if (own_drop || force_rel) begin
                        preempt_q <= force_rel;
                        ptr_q     <= ptr_rel;
`ifdef BUS_TURNAROUND_EN
                        enable_q  <= '1;
                        busy_q    <= 1'b0;
                        hold_q    <= '0;
                        state_q   <= ST_TURN;
`else
                        if (found) begin
                            enable_q <= ~win_mask;
                            owner_q  <= win;
                            busy_q   <= 1'b1;
                            hold_q   <= 8'd1;
                        end else begin
                            enable_q <= '1;
                            busy_q   <= 1'b0;
                            hold_q   <= '0;
                            state_q  <= ST_IDLE;
                        end
`endif
                    end else if (hold_q < HOLD_MAX) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    // IDLE, and the single TURN cycle, both grant from ptr_q.
                    if (found) begin
                        enable_q <= ~win_mask;
                        owner_q  <= win;
                        busy_q   <= 1'b1;
                        hold_q   <= 8'd1;
                        state_q  <= ST_OWN;
                    end else begin
                        enable_q <= '1;
                        busy_q   <= 1'b0;
                        hold_q   <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign enableN  = enable_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - scoreboard bench for tri_bus_arbiter (NUM_DRV=4, MAX_HOLD=8)
module tb_tri_bus_arbiter;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] req    = 4'b1111;
    logic [3:0] enableN;
    logic [1:0] owner;
    logic       bus_busy;
    logic       preempt;

    tri_bus_arbiter #(
        .NUM_DRV  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .req      (req),
        .enableN  (enableN),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         tag;
        logic [3:0] en;
        logic       pre;
        logic       chk_own;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input bit ok, input string what, input int tag, input int act, input int expv);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s (tag %0d, cycle %0d): got %0h expected %0h", what, tag, cyc, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input bit rst, input logic [3:0] r, input int tag,
                        input logic [3:0] en, input logic pre,
                        input logic chk_o, input logic [1:0] own);
        exp_t e;
        @(negedge clk);
        resetN    = rst;
        req       = r;
        e.cyc     = cyc + 1;
        e.tag     = tag;
        e.en      = en;
        e.pre     = pre;
        e.chk_own = chk_o;
        e.own     = own;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ones;
        if (cyc >= 1) begin
            ones = $countones(~enableN);
            chk(ones <= 1, "single_enable", 0, ones, 1);
            chk(bus_busy == (ones == 1), "busy_vs_enables", 0, int'(bus_busy), int'(ones == 1));
            if (bus_busy) begin
                chk(enableN[owner] == 1'b0, "owner_bit_low", 0, int'(enableN), int'(owner));
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.cyc == cyc, "sb_order", e.tag, e.cyc, cyc);
            chk(enableN === e.en, "enableN", e.tag, int'(enableN), int'(e.en));
            chk(preempt === e.pre, "preempt", e.tag, int'(preempt), int'(e.pre));
            chk(bus_busy === ~&e.en, "bus_busy", e.tag, int'(bus_busy), int'(~&e.en));
            if (e.chk_own) begin
                chk(owner === e.own, "owner", e.tag, int'(owner), int'(e.own));
            end
        end
    end

    initial begin
        // 1: reset with all requests, then driver 0 granted one cycle after release.
        repeat (3) step(1'b0, 4'b1111, 1, 4'b1111, 1'b0, 1'b1, 2'd0);
        step(1'b1, 4'b1111, 1, 4'b1110, 1'b0, 1'b1, 2'd0);
        step(1'b1, 4'b0000, 1, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0000, 1, 4'b1111, 1'b0, 1'b0, 2'd0);

        // 2: driver 2 alone for 20 cycles, never preempted.
        repeat (20) step(1'b1, 4'b0100, 2, 4'b1011, 1'b0, 1'b1, 2'd2);
        step(1'b1, 4'b0000, 2, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0000, 2, 4'b1111, 1'b0, 1'b0, 2'd0);

        // 3: pointer at 3; owner 3 drops with 0 waiting -> wrap to 0.
        step(1'b1, 4'b1000, 3, 4'b0111, 1'b0, 1'b1, 2'd3);
        step(1'b1, 4'b1001, 3, 4'b0111, 1'b0, 1'b1, 2'd3);
`ifdef BUS_TURNAROUND_EN
        step(1'b1, 4'b0001, 3, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0001, 3, 4'b1110, 1'b0, 1'b1, 2'd0);
`else
        step(1'b1, 4'b0001, 3, 4'b1110, 1'b0, 1'b1, 2'd0);
`endif
        step(1'b1, 4'b0000, 3, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0000, 3, 4'b1111, 1'b0, 1'b0, 2'd0);

        // 4: reset while driver 1 owns; pointer returns to 0.
        step(1'b1, 4'b0010, 4, 4'b1101, 1'b0, 1'b1, 2'd1);
        step(1'b1, 4'b0010, 4, 4'b1101, 1'b0, 1'b1, 2'd1);
        step(1'b0, 4'b0010, 4, 4'b1111, 1'b0, 1'b1, 2'd0);
        step(1'b0, 4'b0010, 4, 4'b1111, 1'b0, 1'b1, 2'd0);

        // 5: req=0011 held: driver 0 owns 8 cycles, preempted, then driver 1.
        repeat (8) step(1'b1, 4'b0011, 5, 4'b1110, 1'b0, 1'b1, 2'd0);
`ifdef BUS_TURNAROUND_EN
        step(1'b1, 4'b0011, 5, 4'b1111, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b0011, 5, 4'b1101, 1'b0, 1'b1, 2'd1);
`else
        step(1'b1, 4'b0011, 5, 4'b1101, 1'b1, 1'b1, 2'd1);
`endif
        step(1'b1, 4'b0011, 5, 4'b1101, 1'b0, 1'b1, 2'd1);
        step(1'b1, 4'b0011, 5, 4'b1101, 1'b0, 1'b1, 2'd1);
        step(1'b1, 4'b0000, 5, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0000, 5, 4'b1111, 1'b0, 1'b0, 2'd0);

        // 6: pointer at 2; a non-owner request pulse does not disturb owner 2.
        step(1'b1, 4'b0100, 6, 4'b1011, 1'b0, 1'b1, 2'd2);
        step(1'b1, 4'b0101, 6, 4'b1011, 1'b0, 1'b1, 2'd2);
        step(1'b1, 4'b0100, 6, 4'b1011, 1'b0, 1'b1, 2'd2);
        step(1'b1, 4'b0000, 6, 4'b1111, 1'b0, 1'b0, 2'd0);
        step(1'b1, 4'b0000, 6, 4'b1111, 1'b0, 1'b0, 2'd0);

        repeat (3) @(negedge clk);
        chk(sb.size() == 0, "sb_drained", 0, sb.size(), 0);

        // Random requests; the monitor checks enable exclusivity every cycle.
        repeat (10000) begin
            @(negedge clk);
            req = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Round-robin arbiter that owns the active-low enables of every inverting tri-state driver sharing one bus net. It sits directly upstream of those drivers: each driver's `enableN` input is one bit of this block's `enableN` output. The arbiter guarantees that at most one driver is enabled in any cycle and bounds each owner's tenure. It also inserts an optional idle turnaround cycle between owners, so two drivers never fight on `tri_outN`.

## Interface
Parameters:
- NUM_DRV, default 4: number of tri-state drivers on the bus (2..8).
- MAX_HOLD, default 8: maximum consecutive cycles one owner keeps the bus while others wait (1..255).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- resetN  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req  input  NUM_DRV  per-driver bus request, level-sensitive, active-high.
- enableN  output  NUM_DRV  per-driver active-low tri-state enable; at most one bit low.
- owner  output  $clog2(NUM_DRV)  index of current owner; valid only when bus_busy=1.
- bus_busy  output  1  high while any enableN bit is low.
- preempt  output  1  one-cycle pulse when an owner is forcibly released by MAX_HOLD.

## Operation
- All outputs are registered.
- Reset values: enableN all ones, owner 0, bus_busy 0, preempt 0, hold counter 0, priority pointer 0, state IDLE.
- State IDLE: all enables high.
  - If any req is set, pick a winner by round-robin starting at the priority pointer.
  - Go to OWN with that winner's enableN bit low.
- State OWN: the hold counter increments each cycle, saturating at MAX_HOLD.
  - Owner's req still high, and (no other req, or counter < MAX_HOLD): stay in OWN.
  - Owner drops req: release.
  - Counter reaches MAX_HOLD while another req is high: release and pulse preempt.
- Release: the owner's enableN goes high, and the priority pointer moves to owner+1 modulo NUM_DRV.
  - The next state is TURN if the turnaround feature is enabled, otherwise the handover state below.
- Handover (feature disabled):
  - If another req is pending, grant it in the same cycle the old enable rises; state stays OWN and the counter resets to 1.
  - Otherwise go to IDLE.
- State TURN: exactly one cycle with all enables high. Then IDLE behaviour applies: grant the next round-robin winner if any req is set.
- Round-robin: search starts at the pointer and wraps from NUM_DRV-1 to 0. A just-released owner is the lowest priority for the next grant, including a preempted owner that still requests.
- Only the current owner's req is examined for release. A req from a non-owner that rises and falls while it is not owner is ignored.
- Reset mid-tenure: on the next edge all enables go high and every register returns to its reset value.

## Timing
- Grant latency: req seen high at edge N drives enableN low after edge N (one-cycle latency from an idle bus).
- Release: the owner's req seen low at edge N raises its enableN after edge N.
- Next grant lands after edge N+1 with turnaround enabled, or after edge N without it.
- Preempt pulse is high for exactly the one cycle following the release edge.
- bus_busy equals the NAND-reduction of enableN and is registered alongside it, so it never glitches.

## Configuration
- BUS_TURNAROUND_EN defined: the TURN state is compiled in. Every ownership change passes through one all-high cycle, giving the previous driver's output time to float before the next one drives.
- Not defined: the TURN state and its transitions are absent. Handover is back-to-back with no idle cycle, and the enables are still never simultaneously low.

## Structure
- Package tri_bus_pkg holds:
  - the state enum (IDLE, OWN, TURN);
  - the default NUM_DRV and MAX_HOLD constants;
  - the owner index width function.
- One combinational sub-module, rr_pick: inputs are the req vector and pointer; outputs are winner index and a found flag. It is instantiated once.
- The hold counter, pointer and FSM live in the top module.

## Test plan
- Reset with req=4'b1111 → enableN stays 4'b1111 during reset; after resetN rises, enableN=4'b1110 and owner=0 one cycle later.
- Driver 2 holds req alone for 20 cycles → enableN=4'b1011 throughout, preempt never pulses, bus_busy=1.
- req=4'b0011 held continuously, MAX_HOLD=8:
  - driver 0 owns for 8 cycles, preempt pulses;
  - with BUS_TURNAROUND_EN, one all-high cycle follows, then driver 1 owns;
  - without it, driver 1 owns on the next cycle.
- Owner 3 drops req while req=4'b1001 → next owner is 0 (wrap-around); owner is never 3 again before 0 is served.
- Every cycle of a 10k-cycle random req run → popcount(~enableN) ≤ 1, and bus_busy matches that popcount.
- resetN asserted while driver 1 owns → enableN=4'b1111 next cycle; after release, pointer=0 and driver 0 wins when req=4'b0011.
